// File: rtl/ro_puf_response_gen_if.sv
// Handshake/result bundle for ro_puf_response_gen.
//   start, challenge          : request and challenge (master -> slave)
//   busy, done                : measurement in progress / one-cycle completion pulse
//   response, unstable        : per-bit response and low-margin flags (slave -> master)
interface ro_puf_response_gen_if #(
  parameter int unsigned SEL_W     = 4,
  parameter int unsigned RESP_BITS = 8
);
  localparam int unsigned CHAL_W = RESP_BITS * 2 * SEL_W;

  logic                 start;
  logic [CHAL_W-1:0]    challenge;
  logic                 busy;
  logic                 done;
  logic [RESP_BITS-1:0] response;
  logic [RESP_BITS-1:0] unstable;

  modport master (
    output start, challenge,
    input  busy, done, response, unstable
  );

  modport slave (
    input  start, challenge,
    output busy, done, response, unstable
  );
endinterface

// File: rtl/ro_puf_response_gen.sv
// Ring-oscillator PUF response generator. Walks the latched challenge one
// oscillator pair at a time: enable the pair, settle, count synchronised rising
// edges of each selected oscillator over a fixed window, then compare.
// Ports:
//   clk, reset         : clock, asynchronous active-low reset
//   bus (slave)        : start/challenge in, busy/done/response/unstable out
//   osc_a, osc_b       : selected oscillator outputs (asynchronous to clk)
//   sel_a, sel_b       : bank mux selects
//   ro_en_a, ro_en_b   : one-hot oscillator enables, zero outside SETTLE/COUNT
module ro_puf_response_gen #(
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned RESP_BITS  = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WINDOW     = 1024,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned MIN_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  ro_puf_response_gen_if.slave     bus,
  input  logic                     osc_a,
  input  logic                     osc_b,
  output logic [SEL_W-1:0]         sel_a,
  output logic [SEL_W-1:0]         sel_b,
  output logic [(1<<SEL_W)-1:0]    ro_en_a,
  output logic [(1<<SEL_W)-1:0]    ro_en_b
);

  localparam int unsigned NOSC    = 1 << SEL_W;
  localparam int unsigned FIELD_W = 2 * SEL_W;
  localparam int unsigned CHAL_W  = RESP_BITS * FIELD_W;
  localparam int unsigned TMR_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned IDX_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    COUNT,
    COMPARE,
    DONE
  } state_t;

  state_t              state;
  logic [CHAL_W-1:0]   chal;
  logic [IDX_W-1:0]    idx;
  logic [TMR_W-1:0]    tmr;
  logic [CNT_W-1:0]    cnt_a;
  logic [CNT_W-1:0]    cnt_b;
  logic                a_s1, a_s2, a_prev;
  logic                b_s1, b_s2, b_prev;

  logic                rise_a_c, rise_b_c;
  logic [CNT_W-1:0]    diff_c;
  logic                gt_c, weak_c;
  logic [IDX_W-1:0]    nidx_c;
  logic [CHAL_W-1:0]   src_c;
  logic [FIELD_W-1:0]  field_c;

  // Extract challenge field i (upper half -> bank A, lower half -> bank B).
  function automatic logic [FIELD_W-1:0] field_of(input logic [CHAL_W-1:0] c,
                                                  input logic [IDX_W-1:0]  i);
    logic [CHAL_W-1:0] sh;
    sh = c >> (32'(i) * FIELD_W);
    return sh[FIELD_W-1:0];
  endfunction

  function automatic logic [NOSC-1:0] onehot(input logic [SEL_W-1:0] s);
    return NOSC'(1) << s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign rise_a_c = a_s2 & ~a_prev;
  assign rise_b_c = b_s2 & ~b_prev;
  assign gt_c     = cnt_a > cnt_b;
  assign diff_c   = gt_c ? (cnt_a - cnt_b) : (cnt_b - cnt_a);
  assign weak_c   = 32'(diff_c) < MIN_MARGIN;

  // Pair to load next: field 0 of the incoming challenge on acceptance,
  // otherwise the following field of the latched challenge.
  always_comb begin
    nidx_c  = '0;
    src_c   = chal;
    if (state == IDLE) begin
      src_c = bus.challenge;
    end else begin
      nidx_c = idx + IDX_W'(1);
    end
    field_c = field_of(src_c, nidx_c);
  end

  // Sequencer, counters and free-running synchronisers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      chal         <= '0;
      idx          <= '0;
      tmr          <= '0;
      cnt_a        <= '0;
      cnt_b        <= '0;
      a_s1         <= 1'b0;
      a_s2         <= 1'b0;
      a_prev       <= 1'b0;
      b_s1         <= 1'b0;
      b_s2         <= 1'b0;
      b_prev       <= 1'b0;
      sel_a        <= '0;
      sel_b        <= '0;
      ro_en_a      <= '0;
      ro_en_b      <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.response <= '0;
      bus.unstable <= '0;
    end else begin
      a_s1   <= osc_a;
      a_s2   <= a_s1;
      a_prev <= a_s2;
      b_s1   <= osc_b;
      b_s2   <= b_s1;
      b_prev <= b_s2;

      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            chal         <= bus.challenge;
            idx          <= '0;
            tmr          <= '0;
            cnt_a        <= '0;
            cnt_b        <= '0;
            bus.response <= '0;
            bus.unstable <= '0;
            bus.busy     <= 1'b1;
            sel_a        <= field_c[FIELD_W-1:SEL_W];
            sel_b        <= field_c[SEL_W-1:0];
            ro_en_a      <= onehot(field_c[FIELD_W-1:SEL_W]);
            ro_en_b      <= onehot(field_c[SEL_W-1:0]);
            state        <= SETTLE;
          end
        end

        // Counters held at zero, so an edge seen here is never counted.
        SETTLE: begin
          cnt_a <= '0;
          cnt_b <= '0;
          if (tmr == TMR_W'(SETTLE_CYC - 1)) begin
            tmr   <= '0;
            state <= COUNT;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        COUNT: begin
          if (rise_a_c) cnt_a <= sat_inc(cnt_a);
          if (rise_b_c) cnt_b <= sat_inc(cnt_b);
          if (tmr == TMR_W'(WINDOW - 1)) begin
            tmr     <= '0;
            ro_en_a <= '0;
            ro_en_b <= '0;
            state   <= COMPARE;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        COMPARE: begin
          bus.response[idx] <= gt_c;
          bus.unstable[idx] <= weak_c;
          if (idx == IDX_W'(RESP_BITS - 1)) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            idx     <= nidx_c;
            cnt_a   <= '0;
            cnt_b   <= '0;
            sel_a   <= field_c[FIELD_W-1:SEL_W];
            sel_b   <= field_c[SEL_W-1:0];
            ro_en_a <= onehot(field_c[FIELD_W-1:SEL_W]);
            ro_en_b <= onehot(field_c[SEL_W-1:0]);
            state   <= SETTLE;
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_response_gen.sv
// Directed bench for ro_puf_response_gen: three instances sharing stimulus
// (base config, MIN_MARGIN=3, CNT_W=2/WINDOW=32), table of oscillator
// patterns plus hand-written reset and restart sequences.
module tb_ro_puf_response_gen;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned RB    = 2;
  localparam int unsigned CHW   = RB * 2 * SEL_W;
  localparam int unsigned NOSC  = 1 << SEL_W;
  localparam int          LOOP_N = 80;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [CHW-1:0] challenge;
  int   mode_a, mode_b;
  logic [7:0] tb_cnt = 8'd0;
  logic osc_a, osc_b;

  always #5 clk = ~clk;

  // Oscillator model: mode 4 -> period 4 clk, mode 8 -> period 8 clk, else 0.
  always @(negedge clk) tb_cnt <= tb_cnt + 8'd1;
  assign osc_a = (mode_a == 4) ? tb_cnt[1] : (mode_a == 8) ? tb_cnt[2] : 1'b0;
  assign osc_b = (mode_b == 4) ? tb_cnt[1] : (mode_b == 8) ? tb_cnt[2] : 1'b0;

  ro_puf_response_gen_if #(.SEL_W(SEL_W), .RESP_BITS(RB)) if0 ();
  ro_puf_response_gen_if #(.SEL_W(SEL_W), .RESP_BITS(RB)) if1 ();
  ro_puf_response_gen_if #(.SEL_W(SEL_W), .RESP_BITS(RB)) if2 ();

  assign if0.start = start;  assign if0.challenge = challenge;
  assign if1.start = start;  assign if1.challenge = challenge;
  assign if2.start = start;  assign if2.challenge = challenge;

  logic [SEL_W-1:0] sel_a [3];
  logic [SEL_W-1:0] sel_b [3];
  logic [NOSC-1:0]  en_a  [3];
  logic [NOSC-1:0]  en_b  [3];
  logic [RB-1:0]    resp_v [3];
  logic [RB-1:0]    unst_v [3];
  logic             busy_v [3];
  logic             done_v [3];

  assign resp_v[0] = if0.response; assign unst_v[0] = if0.unstable;
  assign busy_v[0] = if0.busy;     assign done_v[0] = if0.done;
  assign resp_v[1] = if1.response; assign unst_v[1] = if1.unstable;
  assign busy_v[1] = if1.busy;     assign done_v[1] = if1.done;
  assign resp_v[2] = if2.response; assign unst_v[2] = if2.unstable;
  assign busy_v[2] = if2.busy;     assign done_v[2] = if2.done;

  ro_puf_response_gen #(.SEL_W(SEL_W), .RESP_BITS(RB), .CNT_W(16), .WINDOW(16),
                        .SETTLE_CYC(2), .MIN_MARGIN(2)) dut0 (
    .clk(clk), .reset(reset), .bus(if0), .osc_a(osc_a), .osc_b(osc_b),
    .sel_a(sel_a[0]), .sel_b(sel_b[0]), .ro_en_a(en_a[0]), .ro_en_b(en_b[0]));

  ro_puf_response_gen #(.SEL_W(SEL_W), .RESP_BITS(RB), .CNT_W(16), .WINDOW(16),
                        .SETTLE_CYC(2), .MIN_MARGIN(3)) dut1 (
    .clk(clk), .reset(reset), .bus(if1), .osc_a(osc_a), .osc_b(osc_b),
    .sel_a(sel_a[1]), .sel_b(sel_b[1]), .ro_en_a(en_a[1]), .ro_en_b(en_b[1]));

  ro_puf_response_gen #(.SEL_W(SEL_W), .RESP_BITS(RB), .CNT_W(2), .WINDOW(32),
                        .SETTLE_CYC(2), .MIN_MARGIN(2)) dut2 (
    .clk(clk), .reset(reset), .bus(if2), .osc_a(osc_a), .osc_b(osc_b),
    .sel_a(sel_a[2]), .sel_b(sel_b[2]), .ro_en_a(en_a[2]), .ro_en_b(en_b[2]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [CHW-1:0]       ch;
    int                   ma;
    int                   mb;
    int                   poke_at;   // cycle after acceptance to re-pulse start (-1: none)
    logic [CHW-1:0]       poke_ch;
    logic [2:0][RB-1:0]   resp;      // per instance
    logic [2:0][RB-1:0]   unst;
  } vec_t;

  // Done lands at cycle 1+RB*(SETTLE+WINDOW+1) after the accepting edge.
  int exp_done [3] = '{39, 39, 71};
  int done_at  [3];
  int done_cnt [3];
  logic [RB-1:0] resp_cap [3];
  logic [RB-1:0] unst_cap [3];

  // Pulse start, then watch LOOP_N cycles; n counts cycles after the accepting edge.
  task automatic run(input string tag, input logic [CHW-1:0] ch, input int ma, input int mb,
                     input int poke_at, input logic [CHW-1:0] poke_ch);
    mode_a    = ma;
    mode_b    = mb;
    challenge = ch;
    for (int d = 0; d < 3; d++) begin
      done_at[d]  = -1;
      done_cnt[d] = 0;
      resp_cap[d] = '0;
      unst_cap[d] = '0;
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= LOOP_N; n++) begin
      for (int d = 0; d < 3; d++) begin
        if (done_v[d]) begin
          done_cnt[d]++;
          if (done_at[d] < 0) begin
            done_at[d]  = n;
            resp_cap[d] = resp_v[d];
            unst_cap[d] = unst_v[d];
            chk($sformatf("%s d%0d busy_in_done", tag, d), 32'(busy_v[d]), 32'd1);
          end
        end
        if (done_at[d] >= 0 && n == done_at[d] + 1)
          chk($sformatf("%s d%0d busy_after_done", tag, d), 32'(busy_v[d]), 32'd0);
      end
      if (n == 1) begin
        chk($sformatf("%s busy_rise", tag), 32'(busy_v[0]), 32'd1);
        chk($sformatf("%s sel_a bit0", tag), 32'(sel_a[0]), 32'd1);
        chk($sformatf("%s sel_b bit0", tag), 32'(sel_b[0]), 32'd2);
        chk($sformatf("%s en_a bit0", tag), 32'(en_a[0]), 32'h0002);
        chk($sformatf("%s en_b bit0", tag), 32'(en_b[0]), 32'h0004);
      end
      if (n == 10) chk($sformatf("%s en_a count", tag), 32'(en_a[0]), 32'h0002);
      if (n == 19) chk($sformatf("%s en_a compare", tag), 32'(en_a[0]), 32'h0000);
      if (n == 20) begin
        chk($sformatf("%s sel_a bit1", tag), 32'(sel_a[0]), 32'd3);
        chk($sformatf("%s sel_b bit1", tag), 32'(sel_b[0]), 32'd5);
        chk($sformatf("%s en_a bit1", tag), 32'(en_a[0]), 32'h0008);
        chk($sformatf("%s en_b bit1", tag), 32'(en_b[0]), 32'h0020);
      end
      start = (n == poke_at);
      if (n == poke_at) challenge = poke_ch;
      @(negedge clk);
    end
    start = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s d%0d done_cycle", tag, d), 32'(done_at[d]), 32'(exp_done[d]));
      chk($sformatf("%s d%0d done_pulses", tag, d), 32'(done_cnt[d]), 32'd1);
    end
  endtask

  vec_t vecs [6];

  initial begin
    // {challenge, osc_a mode, osc_b mode, poke_at, poke challenge, resp{d2,d1,d0}, unst{d2,d1,d0}}
    vecs[0] = '{16'h3512, 4, 0, -1, 16'h0000, {2'b11, 2'b11, 2'b11}, {2'b00, 2'b00, 2'b00}};
    vecs[1] = '{16'h3512, 8, 8, -1, 16'h0000, {2'b00, 2'b00, 2'b00}, {2'b11, 2'b11, 2'b11}};
    vecs[2] = '{16'h3512, 4, 8, -1, 16'h0000, {2'b00, 2'b11, 2'b11}, {2'b11, 2'b11, 2'b00}};
    vecs[3] = '{16'h3512, 0, 4, -1, 16'h0000, {2'b00, 2'b00, 2'b00}, {2'b00, 2'b00, 2'b00}};
    vecs[4] = '{16'h3512, 4, 0,  5, 16'h0000, {2'b11, 2'b11, 2'b11}, {2'b00, 2'b00, 2'b00}};
    vecs[5] = '{16'h3512, 8, 8, 39, 16'hFFFF, {2'b00, 2'b00, 2'b00}, {2'b11, 2'b11, 2'b11}};

    reset     = 1'b0;
    start     = 1'b0;
    challenge = '0;
    mode_a    = 0;
    mode_b    = 0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset d%0d busy", d), 32'(busy_v[d]), 32'd0);
      chk($sformatf("reset d%0d done", d), 32'(done_v[d]), 32'd0);
      chk($sformatf("reset d%0d resp", d), 32'(resp_v[d]), 32'd0);
      chk($sformatf("reset d%0d unst", d), 32'(unst_v[d]), 32'd0);
      chk($sformatf("reset d%0d sel", d), {24'd0, sel_a[d], sel_b[d]}, 32'd0);
      chk($sformatf("reset d%0d en", d), {en_a[d], en_b[d]}, 32'd0);
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      run($sformatf("v%0d", v), vecs[v].ch, vecs[v].ma, vecs[v].mb, vecs[v].poke_at, vecs[v].poke_ch);
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("v%0d d%0d resp", v, d), 32'(resp_cap[d]), 32'(vecs[v].resp[d]));
        chk($sformatf("v%0d d%0d unst", v, d), 32'(unst_cap[d]), 32'(vecs[v].unst[d]));
        chk($sformatf("v%0d d%0d resp_hold", v, d), 32'(resp_v[d]), 32'(vecs[v].resp[d]));
      end
    end

    // Reset in the middle of bit 1's window, after bit 0 has been written.
    mode_a    = 4;
    mode_b    = 0;
    challenge = 16'h3512;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (27) @(negedge clk);
    chk("midrun resp_bit0", 32'(resp_v[0]), 32'd1);
    chk("midrun busy", 32'(busy_v[0]), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("abort d%0d busy", d), 32'(busy_v[d]), 32'd0);
      chk($sformatf("abort d%0d resp", d), 32'(resp_v[d]), 32'd0);
      chk($sformatf("abort d%0d unst", d), 32'(unst_v[d]), 32'd0);
      chk($sformatf("abort d%0d sel", d), {24'd0, sel_a[d], sel_b[d]}, 32'd0);
      chk($sformatf("abort d%0d en", d), {en_a[d], en_b[d]}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_reset idle busy", 32'(busy_v[0]), 32'd0);
    chk("post_reset idle done", 32'(done_v[0]), 32'd0);

    run("rerun", 16'h3512, 4, 0, -1, 16'h0000);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rerun d%0d resp", d), 32'(resp_cap[d]), 32'd3);
      chk($sformatf("rerun d%0d unst", d), 32'(unst_cap[d]), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
